// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU memory-port arbiter.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IFU_BUSY = 2'd1,
    LSU_BUSY = 2'd2
  } arb_state_t;

  typedef enum logic {
    IFU = 1'b0,
    LSU = 1'b1
  } req_id_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_bus_arbiter_timeout_counter.sv
// Saturating busy-cycle counter; hit flags the last busy cycle before a forced error.
module bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] HIT_VAL = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [CW-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CNT_MAX)) begin
      count <= count + CW'(1);
    end
  end

  // Gated by enable so a 1-cycle timeout cannot fire while idle.
  assign hit = (TIMEOUT_CYCLES != 0) && enable && (count == HIT_VAL);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (IFU) and load/store (LSU).
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int              ADDR_W         = 32,
  parameter int              DATA_W         = 32,
  parameter int              TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0] ERR_RDATA    = ERR_RDATA_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ifu_req_valid,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [1:0]        lsu_size,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [3:0]        lsu_wmask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_size,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_err,
  output logic [ADDR_W-1:0] err_addr,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester raises req_valid with its payload and holds both
  // until its one-cycle resp_valid pulse; it drops req_valid on the next edge.
  // The memory side sees mem_req_valid as a level held until mem_resp_valid
  // pulses or the timeout fires.

  arb_state_t state;
  req_id_t    last_grant;

  logic busy;
  logic hit_raw;
  logic timeout_hit;
  logic end_txn;
  logic grant_lsu;
  logic grant_ifu;
  logic [DATA_W-1:0] resp_rdata;

  assign busy        = (state == IFU_BUSY) || (state == LSU_BUSY);
  assign timeout_hit = hit_raw && !mem_resp_valid;
  assign end_txn     = busy && (mem_resp_valid || timeout_hit);

  // On a tie the requester that did not win last time gets the port.
  assign grant_lsu = lsu_req_valid && (!ifu_req_valid || (last_grant == IFU));
  assign grant_ifu = ifu_req_valid && !grant_lsu;

  bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (!busy || end_txn),
    .enable (busy),
    .hit    (hit_raw)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      last_grant    <= IFU;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_size      <= '0;
      mem_wen       <= 1'b0;
      mem_wdata     <= '0;
      mem_wmask     <= '0;
      bus_err       <= 1'b0;
      err_addr      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_lsu) begin
            state         <= LSU_BUSY;
            last_grant    <= LSU;
            mem_req_valid <= 1'b1;
            mem_addr      <= lsu_addr;
            mem_size      <= lsu_size;
            mem_wen       <= lsu_wen;
            mem_wdata     <= lsu_wdata;
            mem_wmask     <= lsu_wmask;
          end else if (grant_ifu) begin
            state         <= IFU_BUSY;
            last_grant    <= IFU;
            mem_req_valid <= 1'b1;
            mem_addr      <= ifu_addr;
            mem_size      <= SZ_W;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
          end
        end
        IFU_BUSY, LSU_BUSY: begin
          if (end_txn) begin
            state         <= IDLE;
            mem_req_valid <= 1'b0;
          end
          if (timeout_hit) begin
            bus_err <= 1'b1;
            if (!bus_err) begin
              err_addr <= mem_addr;
            end
          end
        end
        default: begin
          state         <= IDLE;
          mem_req_valid <= 1'b0;
        end
      endcase
    end
  end

  // A real response in the timeout cycle wins, so ERR_RDATA only when it is absent.
  assign resp_rdata     = timeout_hit ? ERR_RDATA : mem_rdata;
  assign ifu_resp_valid = (state == IFU_BUSY) && (mem_resp_valid || timeout_hit);
  assign lsu_resp_valid = (state == LSU_BUSY) && (mem_resp_valid || timeout_hit);
  assign ifu_rdata      = resp_rdata;
  assign lsu_rdata      = resp_rdata;
  assign dbg_state      = state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with hand-computed expectations.
module tb_mem_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clock;
  logic          reset;
  logic          ifu_req_valid;
  logic [AW-1:0] ifu_addr;
  logic          ifu_resp_valid;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_req_valid;
  logic [AW-1:0] lsu_addr;
  logic [1:0]    lsu_size;
  logic          lsu_wen;
  logic [DW-1:0] lsu_wdata;
  logic [3:0]    lsu_wmask;
  logic          lsu_resp_valid;
  logic [DW-1:0] lsu_rdata;
  logic          mem_req_valid;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_size;
  logic          mem_wen;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wmask;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_rdata;
  logic          bus_err;
  logic [AW-1:0] err_addr;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad   = 0;

  mem_bus_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8), .ERR_RDATA(32'hDEAD_BEEF)
  ) dut (
    .clock(clock), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_addr(lsu_addr), .lsu_size(lsu_size),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .bus_err(bus_err), .err_addr(err_addr), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // checking
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
  endtask

  task automatic drive_lsu(input logic [AW-1:0] a, input logic [1:0] sz, input logic we,
                           input logic [DW-1:0] wd, input logic [3:0] wm);
    lsu_req_valid = 1'b1;
    lsu_addr      = a;
    lsu_size      = sz;
    lsu_wen       = we;
    lsu_wdata     = wd;
    lsu_wmask     = wm;
  endtask

  initial begin
    ifu_req_valid  = 1'b0;
    ifu_addr       = '0;
    lsu_req_valid  = 1'b0;
    lsu_addr       = '0;
    lsu_size       = '0;
    lsu_wen        = 1'b0;
    lsu_wdata      = '0;
    lsu_wmask      = '0;
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
    do_reset();
    settle();

    // reset state
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_err_addr", err_addr, 0);
    check("rst_state", dbg_state, 0);

    // IFU only, memory responds 3 cycles after mem_req_valid
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0000;
    cyc(); settle();
    check("ifu_req_valid", mem_req_valid, 1);
    check("ifu_mem_addr", mem_addr, 32'h8000_0000);
    check("ifu_mem_size", mem_size, 2);
    check("ifu_mem_wen", mem_wen, 0);
    check("ifu_mem_wmask", mem_wmask, 0);
    check("ifu_state", dbg_state, 1);
    check("ifu_no_resp_c1", ifu_resp_valid, 0);
    cyc(); settle();
    check("ifu_no_resp_c2", ifu_resp_valid, 0);
    cyc(); settle();
    check("ifu_no_resp_c3", ifu_resp_valid, 0);
    cyc();
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h0000_0413;
    settle();
    check("ifu_resp", ifu_resp_valid, 1);
    check("ifu_rdata", ifu_rdata, 32'h0000_0413);
    check("ifu_lsu_quiet", lsu_resp_valid, 0);
    cyc();
    mem_resp_valid = 1'b0;
    ifu_req_valid  = 1'b0;
    settle();
    check("ifu_done_state", dbg_state, 0);
    check("ifu_done_req", mem_req_valid, 0);
    check("ifu_single_pulse", ifu_resp_valid, 0);

    // LSU store, payload held until response
    drive_lsu(32'h8000_1004, 2'd2, 1'b1, 32'h1234_5678, 4'hF);
    cyc(); settle();
    check("st_state", dbg_state, 2);
    for (int i = 0; i < 3; i++) begin
      check("st_addr", mem_addr, 32'h8000_1004);
      check("st_size", mem_size, 2);
      check("st_wen", mem_wen, 1);
      check("st_wdata", mem_wdata, 32'h1234_5678);
      check("st_wmask", mem_wmask, 4'hF);
      check("st_req_valid", mem_req_valid, 1);
      check("st_no_resp", lsu_resp_valid, 0);
      cyc(); settle();
    end
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h0;
    settle();
    check("st_resp", lsu_resp_valid, 1);
    check("st_ifu_quiet", ifu_resp_valid, 0);
    cyc();
    mem_resp_valid = 1'b0;
    lsu_req_valid  = 1'b0;
    settle();
    check("st_done_state", dbg_state, 0);
    check("st_single_pulse", lsu_resp_valid, 0);

    // ties after reset: LSU, then IFU on a second tie, then LSU again
    do_reset();
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0100;
    drive_lsu(32'h8000_2000, 2'd0, 1'b0, 32'h0, 4'h0);
    cyc(); settle();
    check("tie1_state", dbg_state, 2);
    check("tie1_addr", mem_addr, 32'h8000_2000);
    check("tie1_size", mem_size, 0);
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h0000_00AA;
    settle();
    check("tie1_lsu_resp", lsu_resp_valid, 1);
    check("tie1_lsu_rdata", lsu_rdata, 32'h0000_00AA);
    check("tie1_ifu_quiet", ifu_resp_valid, 0);
    cyc();
    mem_resp_valid = 1'b0;
    lsu_addr       = 32'h8000_2004;
    settle();
    check("tie2_idle", dbg_state, 0);
    check("tie2_no_resp", ifu_resp_valid, 0);
    cyc(); settle();
    check("tie2_state", dbg_state, 1);
    check("tie2_addr", mem_addr, 32'h8000_0100);
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h0000_0013;
    settle();
    check("tie2_ifu_resp", ifu_resp_valid, 1);
    check("tie2_lsu_quiet", lsu_resp_valid, 0);
    cyc();
    mem_resp_valid = 1'b0;
    ifu_req_valid  = 1'b0;
    cyc(); settle();
    check("tie3_state", dbg_state, 2);
    check("tie3_addr", mem_addr, 32'h8000_2004);
    mem_resp_valid = 1'b1;
    settle();
    check("tie3_resp", lsu_resp_valid, 1);
    cyc();
    mem_resp_valid = 1'b0;
    lsu_req_valid  = 1'b0;

    // timeout on LSU, memory never answers
    drive_lsu(32'hA000_0000, 2'd2, 1'b0, 32'h0, 4'h0);
    cyc();
    for (int i = 1; i < 8; i++) begin
      settle();
      check("to_no_resp", lsu_resp_valid, 0);
      check("to_err_quiet", bus_err, 0);
      cyc();
    end
    settle();
    check("to_resp", lsu_resp_valid, 1);
    check("to_rdata", lsu_rdata, 32'hDEAD_BEEF);
    cyc();
    lsu_req_valid = 1'b0;
    settle();
    check("to_idle", dbg_state, 0);
    check("to_req_drop", mem_req_valid, 0);
    check("to_bus_err", bus_err, 1);
    check("to_err_addr", err_addr, 32'hA000_0000);

    // second timeout keeps the first error address
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'hB000_0000;
    cyc();
    for (int i = 1; i < 8; i++) begin
      settle();
      check("to2_no_resp", ifu_resp_valid, 0);
      cyc();
    end
    settle();
    check("to2_resp", ifu_resp_valid, 1);
    check("to2_rdata", ifu_rdata, 32'hDEAD_BEEF);
    cyc();
    ifu_req_valid = 1'b0;
    settle();
    check("to2_bus_err", bus_err, 1);
    check("to2_err_addr", err_addr, 32'hA000_0000);

    // reset two cycles into IFU_BUSY
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0040;
    cyc(); settle();
    check("mid_busy", dbg_state, 1);
    cyc(); settle();
    reset = 1'b0;
    settle();
    check("mid_req_drop", mem_req_valid, 0);
    check("mid_no_resp", ifu_resp_valid, 0);
    check("mid_state", dbg_state, 0);
    check("mid_bus_err_clr", bus_err, 0);
    ifu_req_valid = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h0000_0077;
    settle();
    check("stray_ifu", ifu_resp_valid, 0);
    check("stray_lsu", lsu_resp_valid, 0);
    cyc();
    mem_resp_valid = 1'b0;
    settle();
    check("stray_state", dbg_state, 0);
    check("stray_req", mem_req_valid, 0);

    // response races the timeout cycle
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0080;
    cyc();
    for (int i = 1; i < 8; i++) begin
      settle();
      check("race_no_resp", ifu_resp_valid, 0);
      cyc();
    end
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h0000_0005;
    settle();
    check("race_resp", ifu_resp_valid, 1);
    check("race_rdata", ifu_rdata, 32'h0000_0005);
    cyc();
    mem_resp_valid = 1'b0;
    ifu_req_valid  = 1'b0;
    settle();
    check("race_bus_err", bus_err, 0);
    check("race_err_addr", err_addr, 0);
    check("race_idle", dbg_state, 0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single external memory port between the core's instruction-fetch requester (IFU) and load/store requester (LSU).
- Sits between the core's fetch/load-store handshake ports and the memory model/bus.
- Grants one requester at a time and registers the granted request onto the memory port.
- Routes the response back only to the granted requester, and recovers from hung transactions with a timeout and an error response.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 1024, busy cycles before forced error response; 0 disables the timeout.
- ERR_RDATA, 32'hDEAD_BEEF, rdata returned on timeout.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- ifu_req_valid  in  1  fetch request; held with ifu_addr until ifu_resp_valid
- ifu_addr  in  ADDR_W  fetch address
- ifu_resp_valid  out  1  one-cycle fetch response pulse
- ifu_rdata  out  DATA_W  fetched instruction
- lsu_req_valid  in  1  load/store request; held with payload until lsu_resp_valid
- lsu_addr  in  ADDR_W  access address
- lsu_size  in  2  0=byte, 1=half, 2=word
- lsu_wen  in  1  1=store
- lsu_wdata  in  DATA_W  store data
- lsu_wmask  in  4  byte write mask
- lsu_resp_valid  out  1  one-cycle load/store response pulse
- lsu_rdata  out  DATA_W  load data
- mem_req_valid  out  1  memory request; level, held until response or timeout
- mem_addr  out  ADDR_W  registered address
- mem_size  out  2  registered size (IFU grant: 2)
- mem_wen  out  1  registered write enable (IFU grant: 0)
- mem_wdata  out  DATA_W  registered store data
- mem_wmask  out  4  registered mask (IFU grant: 0)
- mem_resp_valid  in  1  one-cycle memory response pulse
- mem_rdata  in  DATA_W  memory read data
- bus_err  out  1  sticky; set on any timeout
- err_addr  out  ADDR_W  address of the first timed-out transaction

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All mem_* outputs, bus_err, err_addr and the timeout counter are cleared to 0.
  - last_grant is set to IFU.
  - Any in-flight transaction is abandoned with no response.
- Response outputs are combinational:
  - ifu_resp_valid = (state==IFU_BUSY) & (mem_resp_valid | timeout_hit).
  - lsu_resp_valid is the same, qualified with LSU_BUSY.
  - rdata = mem_rdata, or ERR_RDATA when timeout_hit & ~mem_resp_valid.
  - Both resp outputs are 0 in IDLE and when not granted.
- States: IDLE, IFU_BUSY, LSU_BUSY.
- IDLE:
  - Only lsu_req_valid: grant LSU.
  - Only ifu_req_valid: grant IFU.
  - Both: grant the one opposite last_grant (round-robin), so LSU wins the first tie after reset.
  - Grant latches the payload into the mem_* registers, sets mem_req_valid=1 and updates last_grant.
  - The grant edge is the edge ending the cycle in which the request was sampled; mem_req_valid is high the next cycle.
- BUSY:
  - mem_req_valid and payload are held stable.
  - The counter increments every busy cycle.
  - On mem_resp_valid: return to IDLE on the next edge with mem_req_valid=0 and the counter cleared.
  - No new grant occurs in the response cycle.
- Timeout:
  - timeout_hit = (TIMEOUT_CYCLES!=0) & (count==TIMEOUT_CYCLES-1) & ~mem_resp_valid.
  - It produces an error response to the granted requester and a return to IDLE.
  - bus_err is set; err_addr is captured only if bus_err was 0.
- mem_resp_valid and timeout_hit in the same cycle: the real response wins; no error.
- Stray mem_resp_valid in IDLE: ignored, no resp pulse.
- Requesters drop req_valid on the edge after their resp pulse, so the IDLE cycle after a response sees the updated req_valid.
- Minimum latency: request sampled in cycle N; mem_req_valid in N+1; response in the mem_resp_valid cycle M ≥ N+1.
- Back-to-back throughput: one transaction per (memory latency + 1) cycles.
- Request inputs changing while not granted are ignored; a request dropped before grant is never issued.
- Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1; it saturates, never wraps.

Decomposition:
- Shared package mem_bus_pkg holds:
  - the state enum (IDLE/IFU_BUSY/LSU_BUSY);
  - requester-id encoding (IFU=0, LSU=1);
  - size constants SZ_B/SZ_H/SZ_W;
  - the default ERR_RDATA.
- One sub-module, bus_timeout_counter: clear, enable, hit output, TIMEOUT_CYCLES parameter.
- The arbiter FSM and payload registers stay in mem_bus_arbiter.

Test Plan:
- IFU only:
  - Stimulus: ifu_addr=0x8000_0000; memory responds 3 cycles after mem_req_valid with 0x0000_0413.
  - Required: mem_size=2, mem_wen=0; ifu_resp_valid pulses once with ifu_rdata=0x0000_0413; lsu_resp_valid stays 0.
- LSU store:
  - Stimulus: lsu_addr=0x8000_1004, size=2, wen=1, wdata=0x1234_5678, wmask=0xF.
  - Required: mem_* carry exactly those values, stable until mem_resp_valid; single lsu_resp_valid pulse.
- Simultaneous requests after reset:
  - Stimulus: both requesters assert in the same cycle.
  - Required: LSU granted first; IFU granted in the IDLE cycle after the LSU response; a second tie grants IFU.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8; memory never responds to LSU addr 0xA000_0000.
  - Required: lsu_resp_valid with rdata=0xDEAD_BEEF on busy cycle 8; bus_err=1, err_addr=0xA000_0000.
  - A later timeout leaves err_addr unchanged.
- Reset mid-transaction:
  - Stimulus: assert reset two cycles into IFU_BUSY.
  - Required: mem_req_valid drops immediately (asynchronously), no resp pulse; after release, a stray mem_resp_valid is ignored.
- Response racing timeout:
  - Stimulus: mem_resp_valid arrives in the timeout_hit cycle with rdata 0x5.
  - Required: requester receives 0x5; bus_err remains 0.
